// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data RAM between the core (master 0) and a
//   secondary bus master such as a loader or DMA engine (master 1). At most
//   one access is granted per cycle. Read data is captured into a per-master
//   register and returned, with an rvalid pulse, one cycle after the grant.
//
// Handshake (valid/ready): req acts as valid and gnt as ready. A master
//   holds req/we/addr/wdata stable until it sees gnt=1. The transfer happens
//   in exactly the cycle where req && gnt. gnt is combinational from the
//   current requests and the registered arbiter state. It is never high for
//   both masters in the same cycle.
//
// Parameters
//   ADDR_W, DATA_W  address / data width
//   CORE_PRIO       1: master 0 has priority, with a starvation guard for
//                   master 1; 0: two-way round-robin
//   STARVE_LIMIT    consecutive denied cycles before master 1 is forced
//                   through (used only when CORE_PRIO=1; 1..255)
//
// Ports
//   clk, reset                     clock, asynchronous active-low reset
//   m*_req/we/addr/wdata           master request channel
//   m*_gnt                         access accepted this cycle
//   m*_rvalid/rdata                registered read return
//   ram_we/addr/wdata, ram_rdata   RAM port (ram_rdata combinational)
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int CORE_PRIO    = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] wait_cnt;  // consecutive cycles master 1 has been denied
  logic       last;      // master of the most recent grant (round-robin)
  logic       m1_wins;   // master 1 wins if both masters request
  logic       sel1;      // master 1 selected, before reset gating

  always_comb begin
    m1_wins = 1'b0;
    if (CORE_PRIO != 0) begin
      m1_wins = (wait_cnt == LIMIT);
    end else begin
      m1_wins = (last == 1'b0);
    end
    sel1 = m1_req && (!m0_req || m1_wins);
    // reset gates the grants combinationally so nothing is accepted, and
    // nothing is written, while reset is held low
    m1_gnt = sel1 && reset;
    m0_gnt = m0_req && !sel1 && reset;
  end

  // With no grant the RAM port follows master 0; ram_we stays low.
  always_comb begin
    ram_addr  = m1_gnt ? m1_addr  : m0_addr;
    ram_wdata = m1_gnt ? m1_wdata : m0_wdata;
    ram_we    = m1_gnt ? m1_we    : (m0_gnt && m0_we);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= 8'd0;
      last      <= 1'b1;  // master 0 wins the first round-robin conflict
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt && !m0_we;
      m1_rvalid <= m1_gnt && !m1_we;
      if (m0_gnt && !m0_we) m0_rdata <= ram_rdata;
      if (m1_gnt && !m1_we) m1_rdata <= ram_rdata;

      // saturates at the limit so the forced grant cannot be skipped
      if (!m1_req || m1_gnt) begin
        wait_cnt <= 8'd0;
      end else if (wait_cnt != LIMIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (m0_gnt) begin
        last <= 1'b0;
      end else if (m1_gnt) begin
        last <= 1'b1;
      end
    end
  end

endmodule
